shared_net_arbiter: RTL

- Sequential arbiter that grants ownership of one shared single-bit net (e.g. op_out) to exactly one of N_REQ driver blocks at a time.
- Each driver block (AND/OR gate stages) gates its output onto the wire through its oe bit, so the wire never sees two active drivers.
- Sits directly upstream of the driver blocks.
- Round-robin fairness, a bounded hold time, and optional bus turnaround.

---
 rtl/shared_net_arbiter_pkg.sv | 36 +++
 rtl/shared_net_arbiter_rr_pick.sv | 21 ++
 rtl/shared_net_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shared_net_arbiter_pkg.sv
// Shared types and helpers for the shared-net arbiter.
// Optional bus turnaround is enabled by defining ARB_TURNAROUND_EN.
package shared_net_arb_pkg;

  localparam int N_REQ_DEFAULT    = 2;
  localparam int MAX_HOLD_DEFAULT = 8;
  localparam int N_REQ_MAX        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  // Returns {found, index[2:0]} of the first set bit at or after ptr,
  // wrapping modulo n. Only the low n bits of req are considered.
  function automatic logic [3:0] rr_first(input logic [N_REQ_MAX-1:0] req,
                                          input logic [2:0]           ptr,
                                          input int                   n);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = 0; k < N_REQ_MAX; k++) begin
      if (k < n && !res[3]) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[2:0]]) begin
          res[3]   = 1'b1;
          res[2:0] = idx[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shared_net_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
// Used by shared_net_arbiter (build option ARB_TURNAROUND_EN has no effect here).
module rr_pick
  import shared_net_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  logic [3:0] pick;

  assign pick   = rr_first(N_REQ_MAX'(req), 3'(ptr), N_REQ);
  assign winner = pick[ID_W-1:0];
  assign found  = pick[3];

endmodule

// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbiter for one shared net with bounded hold time.
// Define ARB_TURNAROUND_EN to insert a bus-idle TURN cycle between owners.
module shared_net_arbiter
  import shared_net_arb_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEFAULT,
  parameter  int MAX_HOLD = MAX_HOLD_DEFAULT,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] oe,
  output logic [ID_W-1:0]  owner_id,
  output logic             busy
);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  oe_q, oe_d;
  logic [ID_W-1:0]   owner_id_q, owner_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0]  pick_req;
  logic [ID_W-1:0]   pick_ptr;
  logic [ID_W-1:0]   pick_winner;
  logic              pick_found;
  logic [N_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]   next_ptr;
  logic              owner_req;
  logic              competitor;
  logic              hold_limit;

  // While owning, the picker looks past the owner starting at owner+1 so a
  // handoff can be decided in the release cycle itself.
  always_comb begin
    owner_req  = |(req & grant_q);
    competitor = |(req & ~grant_q);
    hold_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    next_ptr   = (owner_id_q == ID_W'(N_REQ - 1)) ? '0 : owner_id_q + ID_W'(1);
    if (state_q == OWN) begin
      pick_req = req & ~grant_q;
      pick_ptr = next_ptr;
    end else begin
      pick_req = req;
      pick_ptr = rr_ptr_q;
    end
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (pick_winner == ID_W'(i));
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .winner (pick_winner),
    .found  (pick_found)
  );

  always_comb begin
    // NOTE: every next-state signal takes its current value first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    oe_d       = oe_q;
    owner_id_d = owner_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = OWN;
          grant_d    = win_onehot;
          oe_d       = win_onehot;
          owner_id_d = pick_winner;
          hold_cnt_d = '0;
        end
      end

      OWN: begin
        if (owner_req && !(hold_limit && competitor)) begin
          if (!competitor)     hold_cnt_d = '0;
          else if (!hold_limit) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          rr_ptr_d = next_ptr;
`ifdef ARB_TURNAROUND_EN
          state_d = TURN;
          grant_d = '0;
          oe_d    = '0;
`else
          if (pick_found) begin
            state_d    = OWN;
            grant_d    = win_onehot;
            oe_d       = win_onehot;
            owner_id_d = pick_winner;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            oe_d    = '0;
          end
`endif
        end
      end

`ifdef ARB_TURNAROUND_EN
      TURN: begin
        state_d = IDLE;
        grant_d = '0;
        oe_d    = '0;
      end
`endif

      default: begin
        state_d = IDLE;
        grant_d = '0;
        oe_d    = '0;
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      oe_q       <= '0;
      owner_id_q <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      oe_q       <= oe_d;
      owner_id_q <= owner_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign oe       = oe_q;
  assign owner_id = owner_id_q;
  assign busy     = |grant_q;

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));
  a_oe_subset     : assert property (@(posedge clk) (oe_q & ~grant_q) == '0);

endmodule
